// File: rtl/decoder_pkg.sv
// Shared types and helpers for the 2-to-4 stretching decoder.
package decoder_pkg;

    // Width of the shared hold/gap down-counter.
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHold = 2'd1,
        StGap  = 2'd2
    } state_e;

    // Decode a 2-bit index into its one-hot form.
    function automatic logic [3:0] onehot4(input logic [1:0] code);
        logic [3:0] one;
        one     = 4'b0001;
        onehot4 = one << code;
    endfunction

endpackage

// File: rtl/decoder_2to4_stretch_hold_timer.sv
// Loadable 8-bit down-counter with terminal-count flag. Shared by the HOLD and
// GAP phases: the phase entry loads (length - 1) and the phase ends on the
// cycle where the count reads zero.
module hold_timer
    import decoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load takes priority; otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/decoder_2to4_stretch.sv
// Registered 2-to-4 decoder with programmable output stretch.
// An accepted {V, Y} code with V = 1 drives dec_out = 1 << Y for HOLD_CYCLES
// cycles, followed by GAP_CYCLES cycles of all-zero output.
// Optional build macro DECODER_2TO4_STRETCH_PENDING_EN adds a one-entry pending
// register so one further event can be accepted while HOLD/GAP is running; it
// launches straight into HOLD when the current event finishes.
module decoder_2to4_stretch
    import decoder_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [1:0] in_code,
    input  logic       in_v,
    output logic       in_ready,
    output logic [3:0] dec_out,
    output logic       dec_active,
    output logic [7:0] evt_count
);

    // Counter reload values are (length - 1); terminal count is zero.
    localparam logic [CNT_W-1:0] HoldLoad = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GapLoad  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
    localparam bit               HasGap   = (GAP_CYCLES != 0);

    state_e           state_q, state_d;
    logic [3:0]       dec_out_q, dec_out_d;
    logic             dec_active_q, dec_active_d;
    logic [7:0]       evt_q, evt_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_tc;

    logic             xfer;
    logic             phase_end;
    logic             launch_ok;
    logic [1:0]       launch_code;

    assign xfer = in_valid && in_ready;

    // Last cycle of the active event: end of HOLD with no gap, or end of GAP.
    assign phase_end = tmr_tc &&
                       ((state_q == StGap) || ((state_q == StHold) && !HasGap));

`ifdef DECODER_2TO4_STRETCH_PENDING_EN
    logic       pend_full_q, pend_full_d;
    logic [1:0] pend_code_q, pend_code_d;

    // Accept while busy as long as the pending slot is free.
    assign in_ready = (state_q == StIdle) || !pend_full_q;

    // A code arriving on the very last busy cycle launches directly, as if it
    // had been sitting in the pending slot.
    assign launch_ok   = pend_full_q || (xfer && in_v && (state_q != StIdle));
    assign launch_code = pend_full_q ? pend_code_q : in_code;

    // Pending slot: filled by a busy-time transfer with V = 1, emptied at launch.
    always_comb begin
        pend_full_d = pend_full_q;
        pend_code_d = pend_code_q;
        if (state_q != StIdle) begin
            if (phase_end && launch_ok) begin
                pend_full_d = 1'b0;
            end else if (xfer && in_v) begin
                pend_full_d = 1'b1;
                pend_code_d = in_code;
            end
        end
    end

    // Pending slot register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_full_q <= 1'b0;
            pend_code_q <= 2'b00;
        end else begin
            pend_full_q <= pend_full_d;
            pend_code_q <= pend_code_d;
        end
    end
`else
    // Busy phases refuse input; the source must hold its code until IDLE.
    assign in_ready    = (state_q == StIdle);
    assign launch_ok   = 1'b0;
    assign launch_code = 2'b00;
`endif

    // Next-state and registered-output computation for IDLE / HOLD / GAP.
    always_comb begin
        state_d      = state_q;
        dec_out_d    = dec_out_q;
        dec_active_d = dec_active_q;
        evt_d        = evt_q;
        tmr_load     = 1'b0;
        tmr_val      = HoldLoad;

        unique case (state_q)
            StIdle: begin
                dec_out_d    = 4'b0000;
                dec_active_d = 1'b0;
                // V = 0 transfers are accepted and dropped here.
                if (xfer && in_v) begin
                    state_d      = StHold;
                    tmr_load     = 1'b1;
                    tmr_val      = HoldLoad;
                    dec_out_d    = onehot4(in_code);
                    dec_active_d = 1'b1;
                    evt_d        = evt_q + 8'd1;
                end
            end

            StHold: begin
                if (tmr_tc) begin
                    if (HasGap) begin
                        state_d      = StGap;
                        tmr_load     = 1'b1;
                        tmr_val      = GapLoad;
                        dec_out_d    = 4'b0000;
                        dec_active_d = 1'b0;
                    end else if (launch_ok) begin
                        state_d      = StHold;
                        tmr_load     = 1'b1;
                        tmr_val      = HoldLoad;
                        dec_out_d    = onehot4(launch_code);
                        dec_active_d = 1'b1;
                        evt_d        = evt_q + 8'd1;
                    end else begin
                        state_d      = StIdle;
                        dec_out_d    = 4'b0000;
                        dec_active_d = 1'b0;
                    end
                end
            end

            StGap: begin
                dec_out_d    = 4'b0000;
                dec_active_d = 1'b0;
                if (tmr_tc) begin
                    if (launch_ok) begin
                        state_d      = StHold;
                        tmr_load     = 1'b1;
                        tmr_val      = HoldLoad;
                        dec_out_d    = onehot4(launch_code);
                        dec_active_d = 1'b1;
                        evt_d        = evt_q + 8'd1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end

            default: begin
                state_d      = StIdle;
                dec_out_d    = 4'b0000;
                dec_active_d = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            dec_out_q    <= 4'b0000;
            dec_active_q <= 1'b0;
            evt_q        <= 8'd0;
        end else begin
            state_q      <= state_d;
            dec_out_q    <= dec_out_d;
            dec_active_q <= dec_active_d;
            evt_q        <= evt_d;
        end
    end

    hold_timer u_hold_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .tc_o       (tmr_tc)
    );

    assign dec_out    = dec_out_q;
    assign dec_active = dec_active_q;
    assign evt_count  = evt_q;

endmodule

// File: tb/tb_decoder_2to4_stretch.sv
// Directed bench for decoder_2to4_stretch. Instance a uses HOLD=4/GAP=1,
// instance b uses HOLD=4/GAP=0 for back-to-back and pending-slot checks.
module tb_decoder_2to4_stretch;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       in_valid_a = 1'b0, in_v_a = 1'b0;
    logic [1:0] in_code_a = 2'b00;
    logic       in_ready_a, dec_active_a;
    logic [3:0] dec_out_a;
    logic [7:0] evt_a;

    logic       in_valid_b = 1'b0, in_v_b = 1'b0;
    logic [1:0] in_code_b = 2'b00;
    logic       in_ready_b, dec_active_b;
    logic [3:0] dec_out_b;
    logic [7:0] evt_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decoder_2to4_stretch #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid_a),
        .in_code    (in_code_a),
        .in_v       (in_v_a),
        .in_ready   (in_ready_a),
        .dec_out    (dec_out_a),
        .dec_active (dec_active_a),
        .evt_count  (evt_a)
    );

    decoder_2to4_stretch #(.HOLD_CYCLES(4), .GAP_CYCLES(0)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid_b),
        .in_code    (in_code_b),
        .in_v       (in_v_b),
        .in_ready   (in_ready_b),
        .dec_out    (dec_out_b),
        .dec_active (dec_active_b),
        .evt_count  (evt_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();
    endtask

    // Wait (bounded) for instance a to be ready, then perform one transfer.
    task automatic send_a(input logic [1:0] code, input logic v);
        int k;
        k = 0;
        while (!in_ready_a && k < 100) begin
            check("onehot_a", 32'($countones(dec_out_a) <= 1), 32'd1);
            tick();
            k++;
        end
        check("ready_wait_a", {31'd0, in_ready_a}, 32'd1);
        in_valid_a = 1'b1;
        in_code_a  = code;
        in_v_a     = v;
        tick();
        in_valid_a = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_dec_out", {28'd0, dec_out_a}, 32'h0);
        check("rst_active", {31'd0, dec_active_a}, 32'h0);
        check("rst_evt", {24'd0, evt_a}, 32'h0);
        check("rst_ready", {31'd0, in_ready_a}, 32'h1);

        // Basic decode: code 3 held 4 cycles, 1 gap cycle, then ready
        send_a(2'd3, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("basic_hold", {28'd0, dec_out_a}, 32'h8);
            check("basic_active", {31'd0, dec_active_a}, 32'h1);
            check("basic_busy", {31'd0, in_ready_a}, 32'h0);
            tick();
        end
        check("basic_gap", {28'd0, dec_out_a}, 32'h0);
        check("basic_gap_active", {31'd0, dec_active_a}, 32'h0);
        check("basic_gap_busy", {31'd0, in_ready_a}, 32'h0);
        tick();
        check("basic_ready", {31'd0, in_ready_a}, 32'h1);
        check("basic_evt", {24'd0, evt_a}, 32'h1);

        // All codes
        do_reset();
        for (int c = 0; c < 4; c++) begin
            send_a(2'(c), 1'b1);
            check("allcodes_dec", {28'd0, dec_out_a}, 32'h1 << c);
        end
        send_a(2'd0, 1'b0);
        check("allcodes_evt", {24'd0, evt_a}, 32'd4);

        // Null code in IDLE
        in_valid_a = 1'b1; in_code_a = 2'd2; in_v_a = 1'b0;
        tick();
        in_valid_a = 1'b0;
        check("null_dec", {28'd0, dec_out_a}, 32'h0);
        check("null_evt", {24'd0, evt_a}, 32'd4);
        check("null_ready", {31'd0, in_ready_a}, 32'h1);

        // Backpressure: in_valid held through HOLD and GAP
        do_reset();
        in_valid_a = 1'b1; in_code_a = 2'd1; in_v_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_evt", {24'd0, evt_a}, 32'd1);
            check("bp_busy", {31'd0, in_ready_a}, 32'h0);
        end
        tick();
        check("bp_evt_end", {24'd0, evt_a}, 32'd1);
        check("bp_ready_end", {31'd0, in_ready_a}, 32'h1);
        in_valid_a = 1'b0;

        // Wrap of evt_count
        do_reset();
        for (int i = 0; i < 255; i++) send_a(2'(i), 1'b1);
        check("wrap_255", {24'd0, evt_a}, 32'd255);
        send_a(2'd2, 1'b1);
        check("wrap_0", {24'd0, evt_a}, 32'd0);

        // Reset mid-HOLD, asynchronous
        do_reset();
        send_a(2'd2, 1'b1);
        tick();
        check("midrst_pre", {28'd0, dec_out_a}, 32'h4);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_dec", {28'd0, dec_out_a}, 32'h0);
        check("midrst_active", {31'd0, dec_active_a}, 32'h0);
        check("midrst_evt", {24'd0, evt_a}, 32'h0);
        #1 rst_n = 1'b1;
        #1;
        check("midrst_ready", {31'd0, in_ready_a}, 32'h1);
        tick();

        // GAP = 0 instance: back-to-back / pending behaviour
        do_reset();
        in_valid_b = 1'b1; in_code_b = 2'd1; in_v_b = 1'b1;
        tick();
        check("b_first", {28'd0, dec_out_b}, 32'h2);
        in_code_b = 2'd2;
`ifdef DECODER_2TO4_STRETCH_PENDING_EN
        check("b_pend_ready", {31'd0, in_ready_b}, 32'h1);
        tick();
        in_valid_b = 1'b0;
        check("b_pend_full", {31'd0, in_ready_b}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("b_hold1", {28'd0, dec_out_b}, 32'h2);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            check("b_hold2", {28'd0, dec_out_b}, 32'h4);
            check("b_evt", {24'd0, evt_b}, 32'd2);
            tick();
        end
        check("b_idle", {28'd0, dec_out_b}, 32'h0);
        check("b_idle_ready", {31'd0, in_ready_b}, 32'h1);
`else
        for (int i = 0; i < 3; i++) begin
            tick();
            check("b_hold1", {28'd0, dec_out_b}, 32'h2);
            check("b_busy", {31'd0, in_ready_b}, 32'h0);
        end
        tick();
        check("b_idle", {28'd0, dec_out_b}, 32'h0);
        check("b_idle_ready", {31'd0, in_ready_b}, 32'h1);
        check("b_evt1", {24'd0, evt_b}, 32'd1);
        tick();
        in_valid_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("b_hold2", {28'd0, dec_out_b}, 32'h4);
            check("b_evt", {24'd0, evt_b}, 32'd2);
            tick();
        end
        check("b_end", {28'd0, dec_out_b}, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
